// File: rtl/lin_trans_coef_gen_if.sv
// Knot-write, control and coefficient-bus bundle for lin_trans_coef_gen.
// The master side drives knots and control; the slave side returns status and active buses.
interface lin_trans_coef_gen_if #(
  parameter int unsigned DSIZE = 12,
  parameter int unsigned DT_I  = 8,
  parameter int unsigned DT_D  = 4
);
  localparam int unsigned DTW = DT_I + DT_D;

  logic                  wr_en;
  logic [4:0]            wr_addr;
  logic [DSIZE-1:0]      wr_x;
  logic [DSIZE-1:0]      wr_y;
  logic                  start;
  logic                  frame_sync;
  logic                  busy;
  logic                  done;
  logic                  pending;
  logic [2:0]            err;
  logic [16*DSIZE-1:0]   M_bus;
  logic [16*DSIZE-1:0]   C_bus;
  logic [16*DTW-1:0]     D_bus;

  modport master (
    output wr_en, wr_addr, wr_x, wr_y, start, frame_sync,
    input  busy, done, pending, err, M_bus, C_bus, D_bus
  );

  modport slave (
    input  wr_en, wr_addr, wr_x, wr_y, start, frame_sync,
    output busy, done, pending, err, M_bus, C_bus, D_bus
  );
endinterface

// File: rtl/lin_trans_coef_gen.sv
// Coefficient generator for a 16-segment piecewise-linear transform: knots -> (M, C, delta)
// via a bit-serial divider into a shadow bank, committed to the active bank on frame_sync.
module lin_trans_coef_gen #(
  parameter int unsigned DSIZE = 12,
  parameter int unsigned DT_I  = 8,
  parameter int unsigned DT_D  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  lin_trans_coef_gen_if.slave  bus
);
  localparam int unsigned DW  = DSIZE + DT_D;
  localparam int unsigned DTW = DT_I + DT_D;
  localparam int unsigned CW  = $clog2(DW);
  localparam logic [DTW-1:0] D_MAX = '1;
  localparam logic [DTW-1:0] D_ONE = DTW'(1) << DT_D;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_STORE, S_DONE} state_e;

  state_e           state_q;
  logic [DSIZE-1:0] x_q [17];
  logic [DSIZE-1:0] y_q [17];
  logic [DSIZE-1:0] m_act_q [16];
  logic [DSIZE-1:0] c_act_q [16];
  logic [DTW-1:0]   d_act_q [16];
  logic [DSIZE-1:0] m_sh_q [16];
  logic [DSIZE-1:0] c_sh_q [16];
  logic [DTW-1:0]   d_sh_q [16];
  logic [3:0]       k_q;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    num_q;
  logic [DW-1:0]    quo_q;
  logic [DSIZE-1:0] rem_q;
  logic [DSIZE-1:0] dx_q;
  logic             force_q;
  logic             busy_q;
  logic             done_q;
  logic             pending_q;
  logic [2:0]       err_q;

  logic [4:0]       k_lo_d, k_hi_d;
  logic [DSIZE-1:0] x_lo_d, x_hi_d, y_lo_d, y_hi_d, dx_d, dy_d;
  logic             bad_x_d, bad_y_d, fits_d;
  logic [DSIZE:0]   trial_d;
  logic [DTW-1:0]   dsat_d;

  // Segment endpoints, one restoring-divide step, and the saturated slope for STORE
  always_comb begin
    k_lo_d  = {1'b0, k_q};
    k_hi_d  = k_lo_d + 5'd1;
    x_lo_d  = x_q[k_lo_d];
    x_hi_d  = x_q[k_hi_d];
    y_lo_d  = y_q[k_lo_d];
    y_hi_d  = y_q[k_hi_d];
    bad_x_d = (x_hi_d <= x_lo_d);
    bad_y_d = (y_hi_d < y_lo_d);
    dx_d    = x_hi_d - x_lo_d;
    dy_d    = y_hi_d - y_lo_d;
    trial_d = {rem_q, num_q[DW-1]};
    fits_d  = (trial_d >= {1'b0, dx_q});
    if (force_q)                    dsat_d = '0;
    else if (quo_q > DW'(D_MAX))    dsat_d = D_MAX;
    else                            dsat_d = quo_q[DTW-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      num_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dx_q      <= '0;
      force_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        x_q[i]     <= DSIZE'(i) << (DSIZE - 4);
        y_q[i]     <= DSIZE'(i) << (DSIZE - 4);
        m_act_q[i] <= DSIZE'(i) << (DSIZE - 4);
        c_act_q[i] <= DSIZE'(i) << (DSIZE - 4);
        d_act_q[i] <= D_ONE;
        m_sh_q[i]  <= DSIZE'(i) << (DSIZE - 4);
        c_sh_q[i]  <= DSIZE'(i) << (DSIZE - 4);
        d_sh_q[i]  <= D_ONE;
      end
      x_q[16] <= '1;
      y_q[16] <= '1;
    end else begin
      done_q <= 1'b0;
      // Knot table is frozen while the divider walks it
      if (bus.wr_en) begin
        if (state_q != S_IDLE) begin
          err_q[2] <= 1'b1;
        end else if (bus.wr_addr <= 5'd16) begin
          x_q[bus.wr_addr] <= bus.wr_x;
          y_q[bus.wr_addr] <= bus.wr_y;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_LOAD;
            k_q       <= '0;
            busy_q    <= 1'b1;
            err_q     <= '0;
            pending_q <= 1'b0;
          end else if (bus.frame_sync && pending_q) begin
            for (int i = 0; i < 16; i++) begin
              m_act_q[i] <= m_sh_q[i];
              c_act_q[i] <= c_sh_q[i];
              d_act_q[i] <= d_sh_q[i];
            end
            pending_q <= 1'b0;
          end
        end
        S_LOAD: begin
          dx_q    <= dx_d;
          num_q   <= DW'(dy_d) << DT_D;
          rem_q   <= '0;
          quo_q   <= '0;
          cnt_q   <= '0;
          force_q <= bad_x_d | bad_y_d;
          if (bad_x_d) err_q[0] <= 1'b1;
          if (bad_y_d) err_q[1] <= 1'b1;
          state_q <= S_DIV;
        end
        S_DIV: begin
          num_q <= num_q << 1;
          if (fits_d) begin
            rem_q <= DSIZE'(trial_d - {1'b0, dx_q});
            quo_q <= {quo_q[DW-2:0], 1'b1};
          end else begin
            rem_q <= trial_d[DSIZE-1:0];
            quo_q <= {quo_q[DW-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) state_q <= S_STORE;
        end
        S_STORE: begin
          m_sh_q[k_q] <= x_lo_d;
          c_sh_q[k_q] <= y_lo_d;
          d_sh_q[k_q] <= dsat_d;
          if (k_q == 4'd15) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            pending_q <= 1'b1;
          end else begin
            k_q     <= k_q + 4'd1;
            state_q <= S_LOAD;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pending = pending_q;
  assign bus.err     = err_q;

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign bus.M_bus[g*DSIZE +: DSIZE] = m_act_q[g];
    assign bus.C_bus[g*DSIZE +: DSIZE] = c_act_q[g];
    assign bus.D_bus[g*DTW +: DTW]     = d_act_q[g];
  end
endmodule

// File: tb/tb_lin_trans_coef_gen.sv
// Bench for lin_trans_coef_gen: directed coefficient tables, busy-time interference,
// mid-run reset and randomized knots checked against an arithmetic model.
module tb_lin_trans_coef_gen;
  localparam int unsigned DSIZE = 12;
  localparam int unsigned DT_I  = 8;
  localparam int unsigned DT_D  = 4;
  localparam int unsigned DTW   = DT_I + DT_D;
  localparam int unsigned DW    = DSIZE + DT_D;
  localparam int          LAT   = 1 + 16 * (DW + 2);
  localparam int          DMAX  = (1 << DTW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lin_trans_coef_gen_if #(.DSIZE(DSIZE), .DT_I(DT_I), .DT_D(DT_D)) ifc ();
  lin_trans_coef_gen #(.DSIZE(DSIZE), .DT_I(DT_I), .DT_D(DT_D)) dut (
    .clock(clk), .reset(rst), .bus(ifc.slave)
  );

  typedef struct { int scen; int seg; int m; int c; int d; } vec_t;
  vec_t vt [14];

  int total = 0;
  int bad   = 0;
  int kx [17], ky [17];
  int nx [17], ny [17];
  int act_m [16], act_c [16], act_d [16];
  int sh_m [16], sh_c [16], sh_d [16];
  int exp_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_bank(input string tag);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s M[%0d]", tag, k), 32'(ifc.M_bus[k*DSIZE +: DSIZE]), act_m[k]);
      check($sformatf("%s C[%0d]", tag, k), 32'(ifc.C_bus[k*DSIZE +: DSIZE]), act_c[k]);
      check($sformatf("%s D[%0d]", tag, k), 32'(ifc.D_bus[k*DTW +: DTW]), act_d[k]);
    end
  endtask

  task automatic check_table(input int scen);
    for (int i = 0; i < 14; i++) begin
      if (vt[i].scen == scen) begin
        check($sformatf("tbl%0d M[%0d]", scen, vt[i].seg), 32'(ifc.M_bus[vt[i].seg*DSIZE +: DSIZE]), vt[i].m);
        check($sformatf("tbl%0d C[%0d]", scen, vt[i].seg), 32'(ifc.C_bus[vt[i].seg*DSIZE +: DSIZE]), vt[i].c);
        check($sformatf("tbl%0d D[%0d]", scen, vt[i].seg), 32'(ifc.D_bus[vt[i].seg*DTW +: DTW]), vt[i].d);
      end
    end
  endtask

  // Identity transform and reset knot table
  function automatic void model_reset();
    for (int k = 0; k < 16; k++) begin
      kx[k] = k * 256; ky[k] = k * 256;
      act_m[k] = k * 256; act_c[k] = k * 256; act_d[k] = 16;
      sh_m[k] = act_m[k]; sh_c[k] = act_c[k]; sh_d[k] = 16;
    end
    kx[16] = 4095; ky[16] = 4095;
    exp_err = 0;
  endfunction

  // Slope of each segment as floor(dy*2^DT_D/dx), saturated, zero on bad knots
  function automatic void model_compute();
    exp_err = 0;
    for (int k = 0; k < 16; k++) begin
      sh_m[k] = kx[k];
      sh_c[k] = ky[k];
      if (kx[k+1] <= kx[k]) exp_err |= 1;
      if (ky[k+1] < ky[k])  exp_err |= 2;
      if (kx[k+1] <= kx[k] || ky[k+1] < ky[k]) sh_d[k] = 0;
      else begin
        sh_d[k] = ((ky[k+1] - ky[k]) * (1 << DT_D)) / (kx[k+1] - kx[k]);
        if (sh_d[k] > DMAX) sh_d[k] = DMAX;
      end
    end
  endfunction

  task automatic write_knot(input int a, input int x, input int y);
    ifc.wr_en = 1'b1; ifc.wr_addr = 5'(a); ifc.wr_x = DSIZE'(x); ifc.wr_y = DSIZE'(y);
    tick();
    ifc.wr_en = 1'b0;
    if (a <= 16) begin kx[a] = x; ky[a] = y; end
  endtask

  task automatic load_knots();
    for (int a = 0; a < 17; a++) write_knot(a, nx[a], ny[a]);
  endtask

  function automatic void scen1_knots();
    for (int k = 0; k < 16; k++) begin nx[k] = k * 256; ny[k] = k * 128; end
    nx[16] = 4095; ny[16] = 2047;
  endfunction

  task automatic run_compute(input string tag);
    int n;
    model_compute();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    n = 0;
    while (ifc.done !== 1'b1 && n < LAT + 20) begin tick(); n++; end
    check({tag, " latency"}, 32'(n), LAT - 1);
    check({tag, " pending@done"}, 32'(ifc.pending), 1);
    check({tag, " err"}, 32'(ifc.err), exp_err);
    tick();
    check({tag, " busy after"}, 32'(ifc.busy), 0);
  endtask

  task automatic commit(input string tag);
    ifc.frame_sync = 1'b1;
    tick();
    ifc.frame_sync = 1'b0;
    for (int k = 0; k < 16; k++) begin act_m[k] = sh_m[k]; act_c[k] = sh_c[k]; act_d[k] = sh_d[k]; end
    check({tag, " pending clr"}, 32'(ifc.pending), 0);
  endtask

  initial begin
    int n;
    vt[0]  = '{0, 0,  'h000, 'h000, 'h010};
    vt[1]  = '{0, 3,  'h300, 'h300, 'h010};
    vt[2]  = '{0, 15, 'hF00, 'hF00, 'h010};
    vt[3]  = '{1, 0,  'h000, 'h000, 'h008};
    vt[4]  = '{1, 3,  'h300, 'h180, 'h008};
    vt[5]  = '{1, 15, 'hF00, 'h780, 'h007};
    vt[6]  = '{2, 0,  'h000, 'h000, 'hFFF};
    vt[7]  = '{2, 1,  'h001, 'hFFF, 'h000};
    vt[8]  = '{2, 7,  'h700, 'hFFF, 'h000};
    vt[9]  = '{3, 5,  'h500, 'h280, 'h000};
    vt[10] = '{3, 6,  'h500, 'h300, 'h004};
    vt[11] = '{3, 8,  'h800, 'h400, 'h000};
    vt[12] = '{3, 9,  'h900, 'h300, 'h020};
    vt[13] = '{4, 2,  'h200, 'h100, 'h008};

    ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_x = '0; ifc.wr_y = '0;
    ifc.start = 1'b0; ifc.frame_sync = 1'b0;
    model_reset();
    tick(); tick();
    rst = 1'b0;

    check("rst busy", 32'(ifc.busy), 0);
    check("rst pending", 32'(ifc.pending), 0);
    check("rst err", 32'(ifc.err), 0);
    check("rst done", 32'(ifc.done), 0);
    check_table(0);
    check_bank("rst");

    // Uniform knots: active bank must hold until frame_sync
    scen1_knots(); load_knots();
    run_compute("s1");
    check_table(0);
    commit("s1");
    check_table(1);
    check_bank("s1");

    // Steep first segment saturates; flat tail keeps y non-decreasing
    for (int k = 1; k < 17; k++) ny[k] = 4095;
    nx[0] = 0; ny[0] = 0; nx[1] = 1;
    load_knots();
    run_compute("s2");
    commit("s2");
    check_table(2);
    check_bank("s2");

    // Duplicate x and falling y force zero slopes and flag both errors
    scen1_knots(); nx[6] = nx[5]; ny[9] = 'h300;
    load_knots();
    run_compute("s3");
    check("s3 err bits", 32'(ifc.err), 3);
    commit("s3");
    check_table(3);
    check_bank("s3");

    // Leave a result pending, then disturb a second run while it is busy
    scen1_knots(); load_knots();
    run_compute("s4a");
    model_compute();
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    n = 0;
    while (ifc.done !== 1'b1 && n < LAT + 20) begin
      if (n == 20) begin ifc.wr_en = 1'b1; ifc.wr_addr = 5'd2; ifc.wr_x = 'h777; ifc.wr_y = 'h123; end
      if (n == 30) ifc.start = 1'b1;
      if (n == 40) ifc.frame_sync = 1'b1;
      tick();
      ifc.wr_en = 1'b0; ifc.start = 1'b0; ifc.frame_sync = 1'b0;
      n++;
      if (n == 45) begin
        check("s4 busy mid", 32'(ifc.busy), 1);
        check("s4 pending mid", 32'(ifc.pending), 0);
        check_bank("s4 mid");
      end
    end
    check("s4 latency", 32'(n), LAT - 1);
    check("s4 err", 32'(ifc.err), 4);
    ifc.frame_sync = 1'b1; tick(); ifc.frame_sync = 1'b0;
    check("s4 no commit on done", 32'(ifc.pending), 1);
    check_bank("s4 done");
    commit("s4");
    check_table(4);
    check_bank("s4");

    // Reset mid-computation restores identity; later frame_sync is inert
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    check("s5 busy", 32'(ifc.busy), 0);
    check("s5 pending", 32'(ifc.pending), 0);
    check("s5 err", 32'(ifc.err), 0);
    check_bank("s5");
    ifc.frame_sync = 1'b1; tick(); ifc.frame_sync = 1'b0;
    check_bank("s5 fs");

    // Randomized knot tables, including ignored out-of-range addresses
    for (int it = 0; it < 6; it++) begin
      nx[0] = int'($urandom_range(0, 50));
      ny[0] = int'($urandom_range(0, 50));
      for (int k = 1; k < 17; k++) begin
        nx[k] = nx[k-1] + int'($urandom_range(0, 250));
        if ($urandom_range(0, 9) == 0 && ny[k-1] > 0)
          ny[k] = ny[k-1] - int'($urandom_range(1, (ny[k-1] > 50) ? 50 : ny[k-1]));
        else
          ny[k] = ny[k-1] + int'($urandom_range(0, 240));
      end
      load_knots();
      write_knot(int'($urandom_range(17, 31)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      run_compute($sformatf("r%0d", it));
      commit($sformatf("r%0d", it));
      check_bank($sformatf("r%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
